bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Downstream consumer of the binary-to-binary-decimal converter's `BinaryDecimal` output.
- Captures a packed BCD word on a strobe and holds it.
- Time-multiplexes the digits onto a common-segment 7-segment display: per-digit select, segment decode, leading-zero blanking, anti-ghosting dead cycle.
- Sits between the converter and the board pins.

Parameters:
- numberOfDigits, 3, number of BCD digits and display positions (>=1).
- scanDivider, 1000, clock cycles per digit slot (>=2).
- blankLeadingZeros, 1, 1 = blank leading zero digits, 0 = show all digits.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- BinaryDecimal  input  [numberOfDigits-1:0][3:0]  packed BCD from converter; digit 0 is least significant.
- capture  input  1  one-cycle strobe; sample BinaryDecimal.
- digitSelect  output  [numberOfDigits-1:0]  active-low digit enables, one-hot-low or all ones.
- segments  output  [6:0]  active-low {g,f,e,d,c,b,a}.
- frameDone  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Async reset (rst=0): `held`=0, `idx`=0, `cnt`=0, digitSelect=all ones, segments=7'b1111111, frameDone=0. Takes effect immediately, including mid-slot or mid-capture.
- Held register: capture=1 at edge N loads `held` from BinaryDecimal at N. Otherwise `held` holds its value.
- Capture never disturbs `cnt` or `idx`.
- Prescaler `cnt` (width clog2(scanDivider)) counts 0..scanDivider-1. At scanDivider-1: `cnt` goes to 0 and `idx` increments. `idx` wraps from numberOfDigits-1 to 0.
- All outputs are registered, computed each edge from the current `cnt`, `idx` and `held`. Outputs therefore lag state by 1 cycle.
- Capture at edge N updates `held` at N. The new value appears on segments at edge N+1 if that digit is being driven.
- Dead cycle: when `cnt`==0, next digitSelect=all ones and segments=all ones.
- Otherwise, digitSelect=~(1<<idx) and segments=decode(held[idx]). Exception: digit `idx` is blanked, giving all ones on both outputs.
- Blanking rule:
  - Applies only when blankLeadingZeros=1.
  - Digit i>0 is blanked iff held[j]==0 for every j with i<=j<=numberOfDigits-1.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any code 10..15 = 0111111 (dash, g only). A dash digit is nonzero for blanking purposes.
- frameDone: registered. Next value is 1 iff `cnt`==scanDivider-1 and `idx`==numberOfDigits-1, so it is high for exactly one cycle per frame.
- Frame period = numberOfDigits*scanDivider cycles.
- Each slot gives the digit 1 dark cycle followed by scanDivider-1 lit cycles.
- numberOfDigits=1: `idx` stays 0. frameDone pulses every scanDivider cycles.

Test Plan:
- Reset then idle, numberOfDigits=3, scanDivider=4 -> digitSelect/segments all ones until first edge after release. Then digit 0 shows "0" (1000000) on 3 of every 4 cycles. Digits 1,2 stay all ones. frameDone pulses every 12 cycles.
- capture with BinaryDecimal={4'd1,4'd2,4'd3} -> slots show 3 (0110000, select 110), 2 (0100100, select 101), 1 (1111001, select 011). Each slot is preceded by a dark cycle.
- BinaryDecimal={0,0,7}, blankLeadingZeros=1 -> only digit 0 lit with 1111000. With blankLeadingZeros=0 -> digits 2,1 show 1000000.
- BinaryDecimal={0,4'd12,5} -> digit 1 shows dash 0111111, digit 0 shows 5, digit 2 blank.
- capture of new value mid-slot of digit 1 -> segments change on the edge after the `held` update. `cnt`/`idx` sequence and frameDone spacing are unchanged.
- Assert rst=0 mid-slot while digit 1 is lit -> outputs go all ones and frameDone goes to 0 asynchronously. After release, scan restarts at digit 0 with `held`=0.

Source files
------------

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
// Captures a packed BCD word from the binary-to-decimal converter and
// time-multiplexes its digits onto a common-segment 7-segment display.
// Each digit slot lasts scanDivider cycles: one dark cycle with every
// enable off, so the previous digit's segments cannot ghost onto the
// next position, then scanDivider-1 lit cycles.
//
// Ports:
//   clk            single clock, all state on the rising edge
//   rst            asynchronous reset, active low
//   BinaryDecimal  packed BCD input, digit 0 least significant
//   capture        one-cycle strobe that loads BinaryDecimal into the holding register
//   digitSelect    active-low digit enables (one low bit, or all ones when dark)
//   segments       active-low segment drive {g,f,e,d,c,b,a}
//   frameDone      one-cycle pulse marking the end of each full scan
module bcd_display_scan #(
    parameter int numberOfDigits    = 3,
    parameter int scanDivider       = 1000,
    parameter int blankLeadingZeros = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numberOfDigits-1:0][3:0] BinaryDecimal,
    input  logic                           capture,
    output logic [numberOfDigits-1:0]      digitSelect,
    output logic [6:0]                     segments,
    output logic                           frameDone
);

    localparam int CW = (scanDivider > 1) ? $clog2(scanDivider) : 1;
    localparam int IW = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(scanDivider - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(numberOfDigits - 1);
    localparam logic [6:0]    SEG_OFF  = 7'b1111111;

    // Active-low {g..a} pattern for one BCD digit; codes 10..15 show a dash.
    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] pattern;
        case (d)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    logic [numberOfDigits-1:0][3:0] held_r;
    logic [CW-1:0]                  cnt_r;
    logic [IW-1:0]                  idx_r;

    logic                      cntLast_s;
    logic                      idxLast_s;
    logic [3:0]                curDigit_s;
    logic [numberOfDigits-1:0] blankMask_s;
    logic [numberOfDigits-1:0] selNext_s;
    logic [6:0]                segNext_s;
    logic                      frameNext_s;

    // Holding register: loads on the capture strobe, otherwise keeps its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_r <= '0;
        end else if (capture) begin
            held_r <= BinaryDecimal;
        end else begin
            held_r <= held_r;
        end
    end

    // Slot prescaler and digit index; independent of capture activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cntLast_s) begin
            cnt_r <= '0;
            idx_r <= idxLast_s ? '0 : (idx_r + IW'(1));
        end else begin
            cnt_r <= cnt_r + CW'(1);
            idx_r <= idx_r;
        end
    end

    // End-of-slot and end-of-frame flags.
    always_comb begin
        cntLast_s = (cnt_r == CNT_LAST);
        idxLast_s = (idx_r == IDX_LAST);
    end

    // Digit currently addressed by the scan index.
    always_comb begin
        curDigit_s = 4'd0;
        for (int i = 0; i < numberOfDigits; i++) begin
            if (idx_r == IW'(i)) begin
                curDigit_s = held_r[i];
            end else begin
                curDigit_s = curDigit_s;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while every digit so
    // far is zero. Digit 0 is excluded so a zero value still shows "0".
    always_comb begin : blankCalc
        logic zeroRun;
        zeroRun     = 1'b1;
        blankMask_s = '0;
        for (int i = numberOfDigits - 1; i >= 0; i--) begin
            zeroRun        = zeroRun & (held_r[i] == 4'd0);
            blankMask_s[i] = zeroRun & (i != 0) & (blankLeadingZeros != 0);
        end
    end

    // Next output values: dark on the first cycle of each slot and for
    // blanked digits, otherwise enable the indexed digit and drive its pattern.
    always_comb begin
        selNext_s   = '1;
        segNext_s   = SEG_OFF;
        frameNext_s = cntLast_s & idxLast_s;
        if ((cnt_r == '0) || ((blankMask_s & ~selNext_s) != '0)) begin
            selNext_s = '1;
            segNext_s = SEG_OFF;
        end else begin
            selNext_s = '1;
            segNext_s = decodeDigit(curDigit_s);
        end
        for (int i = 0; i < numberOfDigits; i++) begin
            if ((idx_r == IW'(i)) && (cnt_r != '0) && !blankMask_s[i]) begin
                selNext_s[i] = 1'b0;
            end else begin
                selNext_s[i] = selNext_s[i];
            end
        end
        if (selNext_s == '1) begin
            segNext_s = SEG_OFF;
        end else begin
            segNext_s = segNext_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digitSelect <= '1;
            segments    <= SEG_OFF;
            frameDone   <= 1'b0;
        end else begin
            digitSelect <= selNext_s;
            segments    <= segNext_s;
            frameDone   <= frameNext_s;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with 3 digits and a 4-cycle slot.
// Two instances share the inputs: dutA blanks leading zeros, dutB does not.
module tb_bcd_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;

    logic             clk;
    logic             rst;
    logic [2:0][3:0]  bcd;
    logic             capture;
    logic [2:0]       selA, selB;
    logic [6:0]       segA, segB;
    logic             fdA, fdB;

    int passCount  = 0;
    int totalCount = 0;

    bcd_display_scan #(.numberOfDigits(3), .scanDivider(4), .blankLeadingZeros(1)) dutA (
        .clk(clk), .rst(rst), .BinaryDecimal(bcd), .capture(capture),
        .digitSelect(selA), .segments(segA), .frameDone(fdA));

    bcd_display_scan #(.numberOfDigits(3), .scanDivider(4), .blankLeadingZeros(0)) dutB (
        .clk(clk), .rst(rst), .BinaryDecimal(bcd), .capture(capture),
        .digitSelect(selB), .segments(segB), .frameDone(fdB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One vector: optional capture, then the expected patterns {digit2,digit1,digit0}.
    typedef struct {
        logic        doCapture;
        logic [11:0] value;
        logic [20:0] expA;
        logic [20:0] expB;
    } vec_t;

    task automatic chk(input string name, input int phase, input logic [7:0] got, input logic [7:0] exp);
        totalCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s phase %0d got %b expected %b", name, phase, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkOut(input string tag, input int phase,
                          input logic [2:0] eSelA, input logic [6:0] eSegA,
                          input logic [2:0] eSelB, input logic [6:0] eSegB, input logic eFd);
        chk({tag, ".selA"}, phase, {5'd0, selA}, {5'd0, eSelA});
        chk({tag, ".segA"}, phase, {1'b0, segA}, {1'b0, eSegA});
        chk({tag, ".fdA"},  phase, {7'd0, fdA},  {7'd0, eFd});
        chk({tag, ".selB"}, phase, {5'd0, selB}, {5'd0, eSelB});
        chk({tag, ".segB"}, phase, {1'b0, segB}, {1'b0, eSegB});
        chk({tag, ".fdB"},  phase, {7'd0, fdB},  {7'd0, eFd});
    endtask

    // Select pattern implied by an expected segment pattern in slot s.
    function automatic logic [2:0] selFor(input logic [6:0] seg, input int s);
        logic [2:0] one;
        one = 3'b001;
        return (seg == SX) ? 3'b111 : ~(one << s);
    endfunction

    // Checks one full 12-cycle frame; the next edge must be the frame's first.
    task automatic checkFrame(input string tag, input logic [20:0] eA, input logic [20:0] eB);
        logic [6:0] sa, sb;
        for (int p = 0; p < 12; p++) begin
            step();
            if ((p % 4) == 0) begin
                sa = SX;
                sb = SX;
            end else begin
                sa = eA[(p / 4) * 7 +: 7];
                sb = eB[(p / 4) * 7 +: 7];
            end
            chkOut(tag, p, selFor(sa, p / 4), sa, selFor(sb, p / 4), sb, (p == 11));
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 12'h000, {SX, SX, S0}, {S0, S0, S0}};
        vecs[1] = '{1'b1, 12'h123, {S1, S2, S3}, {S1, S2, S3}};
        vecs[2] = '{1'b1, 12'h007, {SX, SX, S7}, {S0, S0, S7}};
        vecs[3] = '{1'b1, 12'h500, {S5, S0, S0}, {S5, S0, S0}};
        vecs[4] = '{1'b1, 12'h986, {S9, S8, S6}, {S9, S8, S6}};
        vecs[5] = '{1'b1, 12'hF04, {SD, S0, S4}, {SD, S0, S4}};
        vecs[6] = '{1'b1, 12'h0C5, {SX, SD, S5}, {S0, SD, S5}};

        rst     = 1'b1;
        capture = 1'b0;
        bcd     = '0;
        #1 rst = 1'b0;
        #1;
        chkOut("resetAsync", -1, 3'b111, SX, 3'b111, SX, 1'b0);
        step();
        step();
        chkOut("resetHeld", -1, 3'b111, SX, 3'b111, SX, 1'b0);
        rst = 1'b1;

        // Idle after reset: two frames of held=0.
        checkFrame("idle0", vecs[0].expA, vecs[0].expB);
        checkFrame("idle1", vecs[0].expA, vecs[0].expB);

        // Table vectors: capture on the first (dark) edge of a frame, let
        // the frame finish, then check the following frame.
        for (int v = 1; v < 7; v++) begin
            capture = vecs[v].doCapture;
            bcd     = vecs[v].value;
            step();
            capture = 1'b0;
            bcd     = 12'h000;
            for (int k = 1; k < 12; k++) step();
            checkFrame($sformatf("vec%0d", v), vecs[v].expA, vecs[v].expB);
        end

        // Capture in the middle of digit 1's slot; held is 0x0C5 here.
        for (int k = 0; k < 6; k++) step();
        chkOut("midPre", 5, 3'b101, SD, 3'b101, SD, 1'b0);
        capture = 1'b1;
        bcd     = 12'h170;
        step();
        capture = 1'b0;
        bcd     = 12'h000;
        chkOut("midOld", 6, 3'b101, SD, 3'b101, SD, 1'b0);
        step();
        chkOut("midNew", 7, 3'b101, S7, 3'b101, S7, 1'b0);
        step();
        chkOut("midDark", 8, 3'b111, SX, 3'b111, SX, 1'b0);
        step();
        chkOut("midD2", 9, 3'b011, S1, 3'b011, S1, 1'b0);
        step();
        chkOut("midD2b", 10, 3'b011, S1, 3'b011, S1, 1'b0);
        step();
        chkOut("midEnd", 11, 3'b011, S1, 3'b011, S1, 1'b1);
        checkFrame("midNext", {S1, S7, S0}, {S1, S7, S0});

        // Asynchronous reset while digit 1 is lit.
        for (int k = 0; k < 6; k++) step();
        chkOut("rstPre", 5, 3'b101, S7, 3'b101, S7, 1'b0);
        #2 rst = 1'b0;
        #1;
        chkOut("rstAsync", 5, 3'b111, SX, 3'b111, SX, 1'b0);
        step();
        chkOut("rstHold", 5, 3'b111, SX, 3'b111, SX, 1'b0);
        rst = 1'b1;
        checkFrame("afterRst", {SX, SX, S0}, {S0, S0, S0});

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
